inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

- Instruction fetch queue between instruction memory fetch and the decode stage.
- Buffers up to DEPTH fetched {PC, instruction} pairs.
- Presents the oldest entry to decode first-word-fall-through, with a valid/ready handshake on both sides.
- Breaks out the 16-bit immediate field, which drives the data_i input of the decode stage's sign-extension unit directly.
- Branch/jump redirect empties the queue with a single-cycle flush.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16.
- PTR_W, 2: log2(DEPTH); pointer width.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous flush (branch taken / jump), active-high.
- enq_valid_i  input  1  fetch side offers an entry.
- enq_ready_o  output  1  queue accepts an entry this cycle.
- enq_pc_i  input  32  PC of offered instruction.
- enq_instr_i  input  32  offered instruction word.
- deq_valid_o  output  1  head entry is valid.
- deq_ready_i  input  1  decode consumes head this cycle.
- deq_pc_o  output  32  head PC.
- deq_instr_o  output  32  head instruction.
- deq_imm_o  output  16  deq_instr_o[15:0]; feeds the sign-extension unit.
- count_o  output  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH × 64 bits; write pointer wp, read pointer rp (PTR_W bits, wrap modulo DEPTH); occupancy counter cnt (PTR_W+1 bits).
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_i.
  - Writes {enq_pc_i, enq_instr_i} at wp.
  - wp increments, wrapping from DEPTH-1 to 0.
- Dequeue fires when deq_valid_o && deq_ready_i && !flush_i; rp increments with the same wrap rule.
- Occupancy update:
  - enqueue only: cnt+1.
  - dequeue only: cnt-1.
  - both: cnt unchanged.
  - neither: unchanged.
- enq_ready_o = (cnt != DEPTH).
  - Full queue does not accept even if a dequeue fires in the same cycle; there is no full-bypass.
- deq_valid_o = (cnt != 0).
  - Empty queue never forwards enq data combinationally; there is no empty-bypass.
- deq_pc_o / deq_instr_o / deq_imm_o:
  - Equal the entry at rp when deq_valid_o = 1.
  - Forced to 0 when empty, so the sign-extension unit sees 16'h0000.
- Flush: on a rising edge with flush_i = 1:
  - wp, rp and cnt all go to 0.
  - The same-cycle enqueue and dequeue are both discarded.
  - Storage contents are left as-is and are unobservable.
- Handshake rules:
  - The fetch side must hold enq_* stable while enq_valid_i && !enq_ready_o.
  - The queue holds its head stable while deq_valid_o && !deq_ready_i.
- Storage array is not reset; all pointers and counters are reset.

## Timing
- Reset (rst_i = 0, asynchronous):
  - wp = rp = cnt = 0.
  - deq_valid_o = 0, enq_ready_o = 1, count_o = 0.
  - deq_pc_o = deq_instr_o = 0, deq_imm_o = 0.
- Reset assertion mid-operation clears state immediately without waiting for a clock edge; all entries are lost.
- Release is synchronous to the next rising edge.
- Enqueue-to-dequeue latency: an entry written at edge N is visible on deq_* and deq_valid_o after edge N (1 cycle).
- Back-to-back throughput: 1 enqueue + 1 dequeue per cycle whenever 0 < cnt < DEPTH.
- enq_ready_o and deq_valid_o depend only on registered cnt; there is no combinational path from deq_ready_i to enq_ready_o.
- Flush latency: deq_valid_o = 0 and enq_ready_o = 1 in the cycle after the flush edge.
- Flush takes priority over every simultaneous event, including a simultaneous enqueue and dequeue at full or empty.

## Test plan
- Reset and empty:
  - Stimulus: assert rst_i = 0 asynchronously mid-cycle with 2 entries queued.
  - Required response: count_o = 0, deq_valid_o = 0, deq_imm_o = 16'h0000 immediately, before any clock edge.
- Fill to full:
  - Stimulus: enqueue 4 entries (PC 0x0, 0x4, 0x8, 0xC; instr 0x2008FFFF, 0x20090010, 0x8D2A8000, 0x00000000) with deq_ready_i = 0.
  - Required response: count_o = 4, enq_ready_o = 0; a fifth offer (PC 0x10) is not accepted.
- In-order drain with immediates:
  - Stimulus: from the full state above, hold deq_ready_i = 1 for 4 cycles.
  - Required response: deq_imm_o = 16'hFFFF, 16'h0010, 16'h8000, 16'h0000 in order.
  - Then deq_valid_o = 0 and count_o = 0.
- Wrap-around streaming:
  - Stimulus: 20 cycles of simultaneous enqueue and dequeue starting at cnt = 2.
  - Required response: count_o stays 2, and PCs come out strictly increasing by 4 across pointer wrap.
- Full with simultaneous dequeue:
  - Stimulus: at cnt = 4, set enq_valid_i = 1 and deq_ready_i = 1.
  - Required response: one entry leaves, nothing enters, count_o = 3 next cycle.
- Flush priority:
  - Stimulus: at cnt = 3, set flush_i = 1 together with enq_valid_i = 1 and deq_ready_i = 1.
  - Required response next cycle: count_o = 0, deq_valid_o = 0, enq_ready_o = 1.
  - The following enqueue of PC 0x40 appears at the head one cycle later.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {PC, instr} pairs
// between fetch and decode, first-word-fall-through, with single-cycle flush.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [31:0]      enq_pc_i,
    input  logic [31:0]      enq_instr_i,
    output logic             deq_valid_o,
    input  logic             deq_ready_i,
    output logic [31:0]      deq_pc_o,
    output logic [31:0]      deq_instr_o,
    output logic [15:0]      deq_imm_o,
    output logic [PTR_W:0]   count_o
);

    logic [63:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             enq_fire;
    logic             deq_fire;
    logic [63:0]      head;

    assign enq_ready_o = (cnt_q != (PTR_W+1)'(DEPTH));
    assign deq_valid_o = (cnt_q != '0);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
    assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (enq_fire) wp_d = wp_q + 1'b1;
            if (deq_fire) rp_d = rp_q + 1'b1;
            unique case ({enq_fire, deq_fire})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[wp_q] <= {enq_pc_i, enq_instr_i};
    end

    // Outputs are zeroed when empty so sign-extension sees 16'h0000.
    assign head        = mem_q[rp_q];
    assign deq_pc_o    = deq_valid_o ? head[63:32] : 32'h0;
    assign deq_instr_o = deq_valid_o ? head[31:0]  : 32'h0;
    assign deq_imm_o   = deq_instr_o[15:0];
    assign count_o     = cnt_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-based model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [31:0] enq_pc_i;
    logic [31:0] enq_instr_i;
    logic        deq_valid_o;
    logic        deq_ready_i;
    logic [31:0] deq_pc_o;
    logic [31:0] deq_instr_o;
    logic [15:0] deq_imm_o;
    logic [PTR_W:0] count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_instr_i(enq_instr_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_instr_o(deq_instr_o),
        .deq_imm_o(deq_imm_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and apply the queue semantics to the model.
    task automatic cycle();
        bit e, d;
        logic [63:0] ent;
        e = enq_valid_i && (q.size() < DEPTH) && !flush_i;
        d = deq_ready_i && (q.size() > 0) && !flush_i;
        ent = {enq_pc_i, enq_instr_i};
        @(posedge clk_i);
        #1;
        if (flush_i) q.delete();
        else begin
            if (d) void'(q.pop_front());
            if (e) q.push_back(ent);
        end
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] ins);
        enq_valid_i = 1'b1;
        enq_pc_i = pc;
        enq_instr_i = ins;
        cycle();
        enq_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; flush_i = 0; enq_valid_i = 0; deq_ready_i = 0;
        enq_pc_i = 0; enq_instr_i = 0;
        @(posedge clk_i); #1;
        checks++;
        if (count_o !== 0 || deq_valid_o !== 0 || enq_ready_o !== 1 ||
            deq_pc_o !== 0 || deq_instr_o !== 0 || deq_imm_o !== 0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d v=%b r=%b pc=%h ins=%h imm=%h required 0 0 1 0 0 0",
                     count_o, deq_valid_o, enq_ready_o, deq_pc_o, deq_instr_o, deq_imm_o);
        end
        rst_i = 1'b1;
        q.delete();
        enq(32'h1000, 32'h1234ABCD);
        enq(32'h1004, 32'h0000BEEF);
        checks++;
        if (count_o !== 2) begin
            errors++;
            $display("FAIL reset_prefill: count=%0d required 2", count_o);
        end
        #3 rst_i = 1'b0;
        #1;
        q.delete();
        checks++;
        if (count_o !== 0 || deq_valid_o !== 0 || deq_imm_o !== 16'h0 || enq_ready_o !== 1) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d v=%b imm=%h r=%b required 0 0 0000 1",
                     count_o, deq_valid_o, deq_imm_o, enq_ready_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] ins [4];
        ins = '{32'h2008FFFF, 32'h20090010, 32'h8D2A8000, 32'h00000000};
        deq_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            enq(32'(i * 4), ins[i]);
            checks++;
            if (count_o !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_count: count=%0d required %0d", count_o, i + 1);
            end
        end
        checks++;
        if (enq_ready_o !== 0) begin
            errors++;
            $display("FAIL full_ready: enq_ready=%b required 0", enq_ready_o);
        end
        enq(32'h10, 32'hDEADBEEF);
        checks++;
        if (count_o !== 4 || deq_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL full_reject: count=%0d head=%h required 4 00000000", count_o, deq_pc_o);
        end
    endtask

    task automatic test_drain();
        logic [15:0] imms [4];
        imms = '{16'hFFFF, 16'h0010, 16'h8000, 16'h0000};
        deq_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (deq_imm_o !== imms[i] || deq_pc_o !== 32'(i * 4) || deq_valid_o !== 1) begin
                errors++;
                $display("FAIL drain_imm[%0d]: imm=%h pc=%h v=%b required %h %h 1",
                         i, deq_imm_o, deq_pc_o, deq_valid_o, imms[i], i * 4);
            end
            cycle();
        end
        deq_ready_i = 0;
        checks++;
        if (deq_valid_o !== 0 || count_o !== 0 || deq_imm_o !== 0) begin
            errors++;
            $display("FAIL drain_empty: v=%b cnt=%0d imm=%h required 0 0 0000",
                     deq_valid_o, count_o, deq_imm_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] next_pc;
        enq(32'h100, 32'h11110000);
        enq(32'h104, 32'h11110004);
        exp_pc = 32'h100;
        next_pc = 32'h108;
        enq_valid_i = 1;
        deq_ready_i = 1;
        for (int i = 0; i < 20; i++) begin
            enq_pc_i = next_pc;
            enq_instr_i = 32'h11110000 | next_pc;
            checks++;
            if (deq_pc_o !== exp_pc || count_o !== 2) begin
                errors++;
                $display("FAIL stream[%0d]: pc=%h cnt=%0d required %h 2",
                         i, deq_pc_o, count_o, exp_pc);
            end
            cycle();
            exp_pc += 4;
            next_pc += 4;
        end
        enq_valid_i = 0;
        deq_ready_i = 0;
        checks++;
        if (count_o !== 2 || deq_pc_o !== exp_pc) begin
            errors++;
            $display("FAIL stream_end: cnt=%0d pc=%h required 2 %h", count_o, deq_pc_o, exp_pc);
        end
    endtask

    task automatic test_full_deq();
        logic [31:0] second;
        enq(32'h200, 32'h22220000);
        enq(32'h204, 32'h22220004);
        second = q[1][63:32];
        enq_valid_i = 1;
        enq_pc_i = 32'h208;
        enq_instr_i = 32'h22220008;
        deq_ready_i = 1;
        cycle();
        enq_valid_i = 0;
        deq_ready_i = 0;
        checks++;
        if (count_o !== 3 || deq_pc_o !== second) begin
            errors++;
            $display("FAIL full_deq: cnt=%0d head=%h required 3 %h", count_o, deq_pc_o, second);
        end
    endtask

    task automatic test_flush();
        flush_i = 1;
        enq_valid_i = 1;
        enq_pc_i = 32'h300;
        enq_instr_i = 32'h33330000;
        deq_ready_i = 1;
        cycle();
        flush_i = 0;
        enq_valid_i = 0;
        deq_ready_i = 0;
        checks++;
        if (count_o !== 0 || deq_valid_o !== 0 || enq_ready_o !== 1 || deq_imm_o !== 0) begin
            errors++;
            $display("FAIL flush: cnt=%0d v=%b r=%b imm=%h required 0 0 1 0000",
                     count_o, deq_valid_o, enq_ready_o, deq_imm_o);
        end
        enq(32'h40, 32'h0000C0DE);
        checks++;
        if (deq_valid_o !== 1 || deq_pc_o !== 32'h40 || deq_imm_o !== 16'hC0DE) begin
            errors++;
            $display("FAIL flush_refill: v=%b pc=%h imm=%h required 1 00000040 c0de",
                     deq_valid_o, deq_pc_o, deq_imm_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] epc, eins;
        bit ev;
        for (int i = 0; i < 400; i++) begin
            if (!(enq_valid_i && !enq_ready_o)) begin
                enq_valid_i = 1'($urandom_range(0, 1));
                enq_pc_i = $urandom;
                enq_instr_i = $urandom;
            end
            deq_ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 19) == 0);
            cycle();
            ev = (q.size() != 0);
            epc = ev ? q[0][63:32] : 32'h0;
            eins = ev ? q[0][31:0] : 32'h0;
            checks++;
            if (deq_valid_o !== ev || enq_ready_o !== (q.size() != DEPTH) ||
                count_o !== 3'(q.size()) || deq_pc_o !== epc ||
                deq_instr_o !== eins || deq_imm_o !== eins[15:0]) begin
                errors++;
                $display("FAIL random[%0d]: v=%b r=%b cnt=%0d pc=%h ins=%h imm=%h required %b %b %0d %h %h %h",
                         i, deq_valid_o, enq_ready_o, count_o, deq_pc_o, deq_instr_o, deq_imm_o,
                         ev, q.size() != DEPTH, q.size(), epc, eins, eins[15:0]);
            end
        end
        enq_valid_i = 0;
        deq_ready_i = 0;
        flush_i = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_deq();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
